// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding FIFO per result producer, round-robin
// selection of a FIFO head, and one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int ROB_SIZE_BIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            clear,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*ROB_SIZE_BIT-1:0] src_rob_id,
  input  logic [NUM_SRC*32-1:0]           src_value,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic                            cdb_valid,
  output logic [ROB_SIZE_BIT-1:0]         cdb_rob_id,
  output logic [31:0]                     cdb_value,
  output logic [1:0]                      cdb_src
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [1:0]       LAST_INIT = 2'(NUM_SRC - 1);

  logic [ROB_SIZE_BIT-1:0] rob_mem [NUM_SRC][FIFO_DEPTH];
  logic [31:0]             val_mem [NUM_SRC][FIFO_DEPTH];

  logic [NUM_SRC-1:0][PTR_W-1:0] head;
  logic [NUM_SRC-1:0][PTR_W-1:0] tail;
  logic [NUM_SRC-1:0][CNT_W-1:0] count;
  logic [1:0]                    last_grant;

  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               any_grant;
  logic [1:0]         winner;
  logic               advance;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign advance = rdy_in & ~clear;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    src_ready = '0;
    nonempty  = '0;
    push      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count[i] < DEPTH_C);
      nonempty[i]  = (count[i] != '0);
      push[i]      = advance & src_valid[i] & src_ready[i];
    end
  end

  // Round-robin scan starting one past the previous winner.
  always_comb begin
    any_grant = 1'b0;
    winner    = last_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!any_grant && nonempty[(int'(last_grant) + 1 + k) % NUM_SRC]) begin
        any_grant = 1'b1;
        winner    = 2'((int'(last_grant) + 1 + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = advance & any_grant & (winner == 2'(i));
    end
  end

  // NOTE: payload storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        rob_mem[i][tail[i]] <= src_rob_id[i*ROB_SIZE_BIT +: ROB_SIZE_BIT];
        val_mem[i][tail[i]] <= src_value[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_grant <= LAST_INIT;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
    end else if (clear) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cdb_valid <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) tail[i] <= ptr_next(tail[i]);
        if (pop[i])  head[i] <= ptr_next(head[i]);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_rob_id <= rob_mem[winner][head[winner]];
        cdb_value  <= val_mem[winner][head[winner]];
        cdb_src    <= winner;
        last_grant <= winner;
      end
    end
  end

endmodule
